// File: rtl/button_conditioner.sv
// Five-button front end: synchronizes, debounces and edge-detects the raw buttons,
// adds auto-repeat on hour/minute, and arbitrates so at most one pulse fires per cycle.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic       mode_btn,
    output logic       add_hour,
    output logic       add_minute,
    output logic       set_timer_btn,
    output logic       set_alarm_btn,
    output logic [4:0] pressed
);

    localparam logic [7:0] DB_LAST     = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] DELAY_LAST  = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rptState_t;

    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] r_pressed;
    logic [7:0] r_dbCnt [5];
    logic [7:0] w_dbNext [5];
    logic [4:0] w_toggle;
    logic [4:0] w_rise;
    logic [4:0] w_fall;

    rptState_t  r_rptState [2];
    rptState_t  w_rptNext [2];
    logic [7:0] r_holdCnt [2];
    logic [7:0] w_holdNext [2];
    logic [1:0] w_rptFire;

    logic [4:0] w_cand;
    logic [4:0] w_grant;
    logic [4:0] r_pulse;

    // Counting stops at the target, so the counter can never wrap.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_dbNext[i] = '0;
            w_toggle[i] = 1'b0;
            if (r_sync2[i] != r_pressed[i]) begin
                if (r_dbCnt[i] >= DB_LAST) begin
                    w_toggle[i] = 1'b1;
                end else begin
                    w_dbNext[i] = r_dbCnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_rise = w_toggle & ~r_pressed;
    assign w_fall = w_toggle & r_pressed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_pressed <= '0;
            for (int i = 0; i < 5; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_pressed <= r_pressed ^ w_toggle;
            for (int i = 0; i < 5; i++) begin
                r_dbCnt[i] <= w_dbNext[i];
            end
        end
    end

    // Repeat schedule for hour (j=0 -> bit1) and minute (j=1 -> bit2); it runs
    // regardless of whether arbitration later drops the pulse it produces.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            w_rptNext[j]  = r_rptState[j];
            w_holdNext[j] = '0;
            w_rptFire[j]  = 1'b0;
            unique case (r_rptState[j])
                RPT_IDLE: begin
                    if (w_rise[j+1]) begin
                        w_rptNext[j] = RPT_DELAY;
                    end
                end
                RPT_DELAY: begin
                    if (w_fall[j+1] || !r_pressed[j+1]) begin
                        w_rptNext[j] = RPT_IDLE;
                    end else if (r_holdCnt[j] >= DELAY_LAST) begin
                        w_rptFire[j] = 1'b1;
                        w_rptNext[j] = RPT_PERIOD;
                    end else begin
                        w_holdNext[j] = r_holdCnt[j] + 8'd1;
                    end
                end
                RPT_PERIOD: begin
                    if (w_fall[j+1] || !r_pressed[j+1]) begin
                        w_rptNext[j] = RPT_IDLE;
                    end else if (r_holdCnt[j] >= PERIOD_LAST) begin
                        w_rptFire[j] = 1'b1;
                    end else begin
                        w_holdNext[j] = r_holdCnt[j] + 8'd1;
                    end
                end
                default: begin
                    w_rptNext[j] = RPT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                r_rptState[j] <= RPT_IDLE;
                r_holdCnt[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                r_rptState[j] <= w_rptNext[j];
                r_holdCnt[j]  <= w_holdNext[j];
            end
        end
    end

    assign w_cand = {w_rise[4], w_rise[3], w_rise[2] | w_rptFire[1],
                     w_rise[1] | w_rptFire[0], w_rise[0]};

    // Losers are simply dropped: mode > timer > alarm > hour > minute.
    always_comb begin
        w_grant = '0;
        if (w_cand[0]) begin
            w_grant[0] = 1'b1;
        end else if (w_cand[3]) begin
            w_grant[3] = 1'b1;
        end else if (w_cand[4]) begin
            w_grant[4] = 1'b1;
        end else if (w_cand[1]) begin
            w_grant[1] = 1'b1;
        end else if (w_cand[2]) begin
            w_grant[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_grant;
        end
    end

    assign mode_btn      = r_pulse[0];
    assign add_hour      = r_pulse[1];
    assign add_minute    = r_pulse[2];
    assign set_timer_btn = r_pulse[3];
    assign set_alarm_btn = r_pulse[4];
    assign pressed       = r_pressed;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a history-based reference model queues
// expected pulses, and a monitor checks every cycle's pulses and debounced levels.
module tb_button_conditioner;

    localparam int D      = 3;
    localparam int DELAY  = 8;
    localparam int PERIOD = 2;
    localparam int HMAX   = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_raw;
    logic       mode_btn, add_hour, add_minute, set_timer_btn, set_alarm_btn;
    logic [4:0] pressed;

    typedef struct {
        int         edgeNo;
        logic [4:0] vec;
    } exp_t;

    exp_t       expQ[$];
    logic [4:0] expPressed = '0;
    int         gEdge = 0;
    int         assertCount = 0;
    int         failCount = 0;

    // Model history, indexed by clock edges since the last reset release.
    bit [4:0]   rawH [0:HMAX-1];
    bit [4:0]   syncH [0:HMAX-1];
    bit [4:0]   presH [0:HMAX-1];
    bit [4:0]   togH [0:HMAX-1];
    int         n = 0;
    int         pressEdge [5];

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .mode_btn(mode_btn),
        .add_hour(add_hour),
        .add_minute(add_minute),
        .set_timer_btn(set_timer_btn),
        .set_alarm_btn(set_alarm_btn),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, gEdge, act, exp);
        end
    endtask

    // A level is accepted once the synchronized input has disagreed with it on D
    // consecutive edges with no acceptance in between; pulses follow from the
    // accepted levels, the press edge and the repeat arithmetic.
    always @(posedge clk) begin : model
        bit [4:0] cand;
        bit       stable;
        int       held;
        int       order [5];
        order = '{0, 3, 4, 1, 2};
        gEdge++;
        if (reset) begin
            n        = 0;
            rawH[0]  = '0;
            syncH[0] = '0;
            presH[0] = '0;
            togH[0]  = '0;
            expPressed = '0;
        end else if (n < HMAX - 1) begin
            n++;
            rawH[n]  = btn_raw;
            syncH[n] = rawH[n-1];
            cand     = '0;
            for (int i = 0; i < 5; i++) begin
                stable = 1'b0;
                if (n >= D) begin
                    stable = 1'b1;
                    for (int k = 0; k < D; k++) begin
                        if (syncH[n-k-1][i] == presH[n-k-1][i]) stable = 1'b0;
                    end
                    for (int k = 1; k < D; k++) begin
                        if (togH[n-k][i]) stable = 1'b0;
                    end
                end
                togH[n][i]  = stable;
                presH[n][i] = presH[n-1][i] ^ stable;
                if (!presH[n-1][i] && presH[n][i]) begin
                    pressEdge[i] = n;
                    cand[i] = 1'b1;
                end else if ((i == 1 || i == 2) && presH[n-1][i] && presH[n][i]) begin
                    held = n - pressEdge[i];
                    if (held >= DELAY && (held - DELAY) % PERIOD == 0) cand[i] = 1'b1;
                end
            end
            expPressed = presH[n];
            for (int p = 0; p < 5; p++) begin
                if (cand[order[p]]) begin
                    expQ.push_back('{edgeNo: gEdge, vec: 5'(1 << order[p])});
                    break;
                end
            end
        end
    end

    // Pops an expectation whenever a pulse shows up, and flags expectations left unmet.
    always @(posedge clk) begin : monitor
        logic [4:0] actual;
        exp_t       e;
        #1;
        actual = {set_alarm_btn, set_timer_btn, add_minute, add_hour, mode_btn};
        checkOutput("pressed", 32'(pressed), 32'(expPressed));
        checkOutput("one_pulse_max", 32'($onehot0(actual)), 32'd1);
        if (actual != '0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pulse", 32'(actual), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse_edge", 32'(gEdge), 32'(e.edgeNo));
                checkOutput("pulse_vec", 32'(actual), 32'(e.vec));
            end
        end else begin
            while (expQ.size() > 0 && expQ[0].edgeNo <= gEdge) begin
                e = expQ.pop_front();
                checkOutput("missed_pulse", 32'(actual), 32'(e.vec));
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] raw, input int cycles);
        @(negedge clk);
        btn_raw = raw;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic pulseReset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_reset",
                    32'({set_alarm_btn, set_timer_btn, add_minute, add_hour, mode_btn, pressed}),
                    32'd0);
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        applyStimulus(5'b00000, 5);

        applyStimulus(5'b00001, 10);   // clean mode press
        applyStimulus(5'b00000, 10);
        applyStimulus(5'b00100, 2);    // glitch on minute
        applyStimulus(5'b00000, 10);
        applyStimulus(5'b00100, 20);   // minute auto-repeat
        applyStimulus(5'b00000, 10);
        applyStimulus(5'b00011, 12);   // mode/hour collision
        applyStimulus(5'b00000, 10);
        applyStimulus(5'b00010, 10);   // hour held through a reset
        pulseReset(2);
        applyStimulus(5'b00010, 20);
        applyStimulus(5'b00000, 10);
        applyStimulus(5'b11000, 15);   // timer beats alarm
        applyStimulus(5'b00000, 10);
        applyStimulus(5'b00010, 2);    // hour and minute repeats collide
        applyStimulus(5'b00110, 30);
        applyStimulus(5'b00000, 10);
        applyStimulus(5'b10101, 300);  // long hold, repeats keep going
        applyStimulus(5'b00000, 10);

        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                pulseReset($urandom_range(1, 3));
            end else begin
                applyStimulus(5'($urandom & $urandom), $urandom_range(1, 12));
            end
        end

        applyStimulus(5'b00000, 20);
        checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
